// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer handshake and line/status signals of the FIFO-buffered UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]        data_in;
    logic                        wr_en;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic                        busy;
    logic                        tx;
    modport master (output data_in, wr_en, input full, fifo_count, overflow, busy, tx);
    modport slave (input data_in, wr_en, output full, fifo_count, overflow, busy, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data bits, parity and stop bits
module uart_tx_fifo #(
    parameter int CLKFREQ    = 50_000_000,
    parameter int BAUDS      = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLKFREQ / BAUDS;
    localparam int DW  = $clog2(DIV + 2);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY < 0 || PARITY > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $fatal(1, "uart_tx_fifo: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q;
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                 full, empty, wr, pop, bit_end;

    assign full    = count_q == DEPTH;
    assign empty   = count_q == '0;
    assign wr      = bus.wr_en && !full;
    assign bit_end = div_q == DIV_LAST;

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) div_d = bit_end ? '0 : div_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                pop     = !empty;
                state_d = empty ? S_IDLE : S_START;
            end
            S_START: begin
                bit_d   = '0;
                state_d = bit_end ? S_DATA : S_START;
            end
            S_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                par_d   = par_q ^ shift_q[0];
                bit_d   = bit_q + 1'b1;
                if (bit_q == LAST_DATA) begin
                    bit_d   = '0;
                    state_d = PARITY != 0 ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                bit_d   = '0;
                state_d = bit_end ? S_STOP : S_PARITY;
            end
            S_STOP: if (bit_end) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST_STOP) begin
                    bit_d   = '0;
                    pop     = !empty;
                    state_d = empty ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rptr_q];
            par_d   = 1'b0;
        end
        // tx is registered, so it reflects the state being entered at this edge
        tx_d = state_d == S_START  ? 1'b0 :
               state_d == S_DATA   ? shift_d[0] :
               state_d == S_PARITY ? par_d ^ (PARITY == 2) : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ovf_q   <= bus.wr_en && full;
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= bus.data_in;
    end

    assign bus.full       = full;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != S_IDLE) || !empty;
    assign bus.tx         = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter configurations driven with directed and random writes,
// compared every cycle against a frame-timing model built on queues and bit arithmetic.
module tb_uart_tx_fifo;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       wr     [4];
    logic [8:0] din    [4];
    logic       tx_o   [4];
    logic       busy_o [4];
    logic       full_o [4];
    logic       ovf_o  [4];
    logic [4:0] cnt_o  [4];

    int db  [4] = '{8, 8, 8, 7};
    int par [4] = '{0, 1, 2, 1};
    int sb  [4] = '{1, 1, 1, 2};
    int dep [4] = '{4, 16, 16, 16};

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  b0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b2 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) b3 ();

    uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUDS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUDS(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUDS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUDS(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    assign b0.wr_en = wr[0];
    assign b1.wr_en = wr[1];
    assign b2.wr_en = wr[2];
    assign b3.wr_en = wr[3];
    assign b0.data_in = din[0][7:0];
    assign b1.data_in = din[1][7:0];
    assign b2.data_in = din[2][7:0];
    assign b3.data_in = din[3][6:0];
    assign tx_o   = '{b0.tx, b1.tx, b2.tx, b3.tx};
    assign busy_o = '{b0.busy, b1.busy, b2.busy, b3.busy};
    assign full_o = '{b0.full, b1.full, b2.full, b3.full};
    assign ovf_o  = '{b0.overflow, b1.overflow, b2.overflow, b3.overflow};
    assign cnt_o  = '{5'(b0.fifo_count), 5'(b1.fifo_count), 5'(b2.fifo_count), 5'(b3.fifo_count)};

    // Model: queued words, the word on the line, and cycles left in its frame (0 = line idle)
    int unsigned mq [4][$];
    int          rem [4];
    int          cur [4];
    bit          ovf_m [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int flen(input int i);
        return (1 + db[i] + (par[i] != 0 ? 1 : 0) + sb[i]) * DIV;
    endfunction

    function automatic logic frame_bit(input int i, input int w, input int k);
        if (k == 0) return 1'b0;
        if (k <= db[i]) return w[k-1];
        if (par[i] != 0 && k == db[i] + 1) return (^w) ^ (par[i] == 2);
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            rem[i]   = 0;
            ovf_m[i] = 1'b0;
            wr[i]    = 1'b0;
            din[i]   = '0;
        end
    endtask

    task automatic model_step();
        bit f, p;
        for (int i = 0; i < 4; i++) begin
            f = mq[i].size() == dep[i];
            p = mq[i].size() > 0 && rem[i] <= 1;
            ovf_m[i] = wr[i] && f;
            if (p) begin
                cur[i] = int'(mq[i].pop_front());
                rem[i] = flen(i);
            end else if (rem[i] > 0) rem[i]--;
            if (wr[i] && !f) mq[i].push_back(int'(din[i]) & ((1 << db[i]) - 1));
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d tx", i), 32'(tx_o[i]),
                  32'(rem[i] == 0 ? 1'b1 : frame_bit(i, cur[i], (flen(i) - rem[i]) / DIV)));
            check($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(rem[i] > 0 || mq[i].size() > 0));
            check($sformatf("u%0d full", i), 32'(full_o[i]), 32'(mq[i].size() == dep[i]));
            check($sformatf("u%0d fifo_count", i), 32'(cnt_o[i]), mq[i].size());
            check($sformatf("u%0d overflow", i), 32'(ovf_o[i]), 32'(ovf_m[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 4; i++) wr[i] = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear before the next clock edge
    task automatic do_reset(input int dly);
        #(dly) rst = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d rst tx", i), 32'(tx_o[i]), 32'd1);
            check($sformatf("u%0d rst busy", i), 32'(busy_o[i]), 32'd0);
            check($sformatf("u%0d rst full", i), 32'(full_o[i]), 32'd0);
            check($sformatf("u%0d rst count", i), 32'(cnt_o[i]), 32'd0);
            check($sformatf("u%0d rst overflow", i), 32'(ovf_o[i]), 32'd0);
        end
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset(3);
        repeat (50) cycle();
        // 8N1 0xA5, 8E1 0x07, 8O1 0x07, 7E2 0x00
        wr  = '{1'b1, 1'b1, 1'b1, 1'b1};
        din = '{9'h0A5, 9'h007, 9'h007, 9'h000};
        cycle();
        repeat (120) cycle();
        // depth-4 FIFO: six consecutive writes, the sixth overflows
        for (int k = 1; k <= 6; k++) begin
            wr[0]  = 1'b1;
            din[0] = 9'(k);
            cycle();
        end
        repeat (520) cycle();
        // back-to-back frames
        for (int k = 0; k < 2; k++) begin
            wr[0]  = 1'b1;
            din[0] = 9'(8'h3C ^ 8'(k * 8'hFF));
            cycle();
        end
        repeat (220) cycle();
        // random traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 3)));
            for (int i = 0; i < 4; i++) begin
                wr[i]  = $urandom_range(0, 99) < 4;
                din[i] = 9'($urandom_range(0, 511));
            end
            cycle();
        end
        // reset during the 4th data bit of a 3-word burst
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            wr[0]  = 1'b1;
            din[0] = 9'(8'h50 + k);
            cycle();
        end
        repeat (40) cycle();
        do_reset(2);
        repeat (50) cycle();
        wr[0]  = 1'b1;
        din[0] = 9'h081;
        cycle();
        repeat (110) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
